// File: rtl/sort_n_floats_seq_if.sv
// Job interface of the sequential N-element float sorter.
// valid_in is a one-cycle request that the sorter takes only while busy=0 (no ready/queueing);
// valid_out is a one-cycle pulse that qualifies sorted and err.
interface sort_n_floats_seq_if #(
    parameter int N    = 4,
    parameter int FLEN = 64
);
    logic                      valid_in;
    logic [0:N-1][FLEN-1:0]    unsorted;
    logic                      busy;
    logic                      valid_out;
    logic [0:N-1][FLEN-1:0]    sorted;
    logic                      err;

    modport master (
        output valid_in, unsorted,
        input  busy, valid_out, sorted, err
    );

    modport slave (
        input  valid_in, unsorted,
        output busy, valid_out, sorted, err
    );
endinterface

// File: rtl/sort_n_floats_seq.sv
// Sequential bubble sorter for N IEEE floats, sharing one less-or-equal comparator.
// The job takes N*(N-1)/2 compare cycles regardless of the data, then pulses valid_out.

module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EW = (FLEN == 64) ? 11 : ((FLEN == 32) ? 8 : 5);
    localparam int MW = FLEN - 1 - EW;

    logic            a_nan;
    logic            b_nan;
    logic            both_zero;
    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;

    assign a_mag     = a[FLEN-2:0];
    assign b_mag     = b[FLEN-2:0];
    assign a_nan     = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
    assign b_nan     = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    // Sign-magnitude ordering; -0 and +0 compare equal, NaN is unordered.
    always_comb begin
        err = a_nan || b_nan;
        res = 1'b0;
        if (a_nan || b_nan) begin
            res = 1'b0;
        end else if (both_zero) begin
            res = 1'b1;
        end else if (a[FLEN-1] != b[FLEN-1]) begin
            res = a[FLEN-1];
        end else if (!a[FLEN-1]) begin
            res = (a_mag <= b_mag);
        end else begin
            res = (a_mag >= b_mag);
        end
    end
endmodule

module sort_n_floats_seq #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    sort_n_floats_seq_if.slave bus,
    output logic [1:0]         state_dbg
);
    localparam int FLEN = 64;
    localparam int CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [0:N-1][FLEN-1:0] w;
    logic [CW-1:0]          pass_q;
    logic [CW-1:0]          idx_q;
    logic                   err_acc;
    logic [FLEN-1:0]        cmp_a;
    logic [FLEN-1:0]        cmp_b;
    logic                   cmp_res;
    logic                   cmp_err;
    logic                   pass_end;
    logic                   last_cmp;

    // Operand select for the single shared comparator: w[idx] vs w[idx+1].
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (idx_q == CW'(i)) begin
                cmp_a = w[i];
                cmp_b = w[i+1];
            end
        end
    end

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    assign pass_end = (idx_q == (LAST - pass_q));
    assign last_cmp = pass_end && (pass_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid_in) state_nxt = SORT;
            SORT:    if (last_cmp) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.valid_out = (state == DONE);
        bus.err       = (state == DONE) && err_acc;
        state_dbg     = state;
    end

    assign bus.sorted = w;

    // Working array and pass/index counters; a swap only happens on strict
    // disorder, so equal keys keep their input order.
    always_ff @(posedge clk) begin
        if (rst) begin
            w       <= '0;
            pass_q  <= '0;
            idx_q   <= '0;
            err_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        w       <= bus.unsorted;
                        pass_q  <= '0;
                        idx_q   <= '0;
                        err_acc <= 1'b0;
                    end
                end
                SORT: begin
                    err_acc <= err_acc | cmp_err;
                    if (!cmp_res) begin
                        for (int i = 0; i < N - 1; i++) begin
                            if (idx_q == CW'(i)) begin
                                w[i]   <= cmp_b;
                                w[i+1] <= cmp_a;
                            end
                        end
                    end
                    if (pass_end) begin
                        idx_q  <= '0;
                        pass_q <= pass_q + 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_n_floats_seq.sv
// Bench for sort_n_floats_seq: N=4 instance checked through a scoreboard,
// plus small N=2 and N=5 instances checked directly.
module tb_sort_n_floats_seq;
    localparam int K4 = 6;
    localparam int K2 = 1;
    localparam int K5 = 10;

    localparam logic [63:0] P3  = 64'h4008000000000000;
    localparam logic [63:0] P2  = 64'h4000000000000000;
    localparam logic [63:0] P1  = 64'h3FF0000000000000;
    localparam logic [63:0] PH  = 64'h3FE0000000000000;
    localparam logic [63:0] M1  = 64'hBFF0000000000000;
    localparam logic [63:0] NAN = 64'h7FF8000000000000;
    localparam logic [63:0] PZ  = 64'h0000000000000000;
    localparam logic [63:0] MZ  = 64'h8000000000000000;

    typedef logic [0:3][63:0] v4_t;
    typedef logic [0:1][63:0] v2_t;
    typedef logic [0:4][63:0] v5_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] st4, st2, st5;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [255:0] exp_q[$];
    logic         exp_err_q[$];
    int           acc_q[$];

    sort_n_floats_seq_if #(.N(4), .FLEN(64)) bus4 ();
    sort_n_floats_seq_if #(.N(2), .FLEN(64)) bus2 ();
    sort_n_floats_seq_if #(.N(5), .FLEN(64)) bus5 ();

    sort_n_floats_seq #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .state_dbg(st4));
    sort_n_floats_seq #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .state_dbg(st2));
    sort_n_floats_seq #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave), .state_dbg(st5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic v4_t model4(input v4_t v);
        v4_t r;
        logic [63:0] t;
        r = v;
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0; j--)
                if ($bitstoreal(r[j-1]) > $bitstoreal(r[j])) begin
                    t = r[j]; r[j] = r[j-1]; r[j-1] = t;
                end
        return r;
    endfunction

    function automatic logic has_nan4(input v4_t v);
        logic n;
        n = 1'b0;
        for (int i = 0; i < 4; i++)
            if ((&v[i][62:52]) && (|v[i][51:0])) n = 1'b1;
        return n;
    endfunction

    function automatic logic [63:0] rand_val();
        return $realtobits(real'(int'($urandom_range(0, 16)) - 8) * 0.5);
    endfunction

    // Expected result, error flag and acceptance cycle for a job taken at the next edge.
    task automatic push_exp(input v4_t v);
        exp_q.push_back(model4(v));
        exp_err_q.push_back(has_nan4(v));
        acc_q.push_back(cyc + 1);
    endtask

    // Called at a negedge while the sorter should be idle.
    task automatic send4(input v4_t v);
        checks++;
        if (bus4.busy !== 1'b0) begin
            errors++;
            $display("FAIL send_idle: busy=%b required 0", bus4.busy);
        end
        bus4.unsorted = v;
        bus4.valid_in = 1'b1;
        push_exp(v);
        @(negedge clk);
        bus4.valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus4.valid_out !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus4.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: valid_out=%b required 1", name, bus4.valid_out);
        end else begin
            @(negedge clk);
            checks++;
            if (bus4.busy !== 1'b0 || bus4.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_after: busy=%b valid_out=%b required 0 0", name, bus4.busy, bus4.valid_out);
            end
        end
    endtask

    // Scoreboard: every valid_out pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (bus4.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out: got pulse, required none");
            end else begin
                logic [255:0] e;
                logic         ee;
                int           a;
                e  = exp_q.pop_front();
                ee = exp_err_q.pop_front();
                a  = acc_q.pop_front();
                checks++;
                if (bus4.err !== ee) begin
                    errors++;
                    $display("FAIL err_flag: got %b required %b", bus4.err, ee);
                end
                checks++;
                if (cyc - a !== K4) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", cyc - a, K4);
                end
                if (!ee) begin
                    checks++;
                    if (bus4.sorted !== e) begin
                        errors++;
                        $display("FAIL sorted: got %h required %h", bus4.sorted, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.busy !== 1'b0 || bus4.valid_out !== 1'b0 || bus4.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b valid_out=%b err=%b required 0 0 0", bus4.busy, bus4.valid_out, bus4.err);
        end
        checks++;
        if (bus4.sorted !== 256'd0) begin
            errors++;
            $display("FAIL reset_sorted: got %h required 0", bus4.sorted);
        end
        checks++;
        if (st4 !== 2'd0 || bus2.busy !== 1'b0 || bus5.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: st4=%0d busy2=%b busy5=%b required 0 0 0", st4, bus2.busy, bus5.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        v4_t exp_v;
        exp_v = {M1, P1, P2, P3};
        send4({P3, P1, P2, M1});
        checks++;
        if (bus4.busy !== 1'b1 || bus4.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b err=%b required 1 0", bus4.busy, bus4.err);
        end
        wait_done("basic");
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.sorted !== exp_v) begin
            errors++;
            $display("FAIL basic_hold: got %h required %h", bus4.sorted, exp_v);
        end
    endtask

    task automatic test_data_independent();
        send4({M1, PH, P1, P2});
        wait_done("presorted");
        send4({P2, P1, PH, M1});
        wait_done("reversed");
    endtask

    task automatic test_nan();
        send4({P1, NAN, P2, PH});
        wait_done("nan");
        send4({P2, P1, P1, PH});
        wait_done("after_nan");
    endtask

    task automatic test_zeros();
        send4({PZ, MZ, M1, P1});
        wait_done("zeros");
    endtask

    task automatic test_back_to_back();
        v4_t v;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 4; j++) v[j] = rand_val();
            bus4.unsorted = v;
            bus4.valid_in = 1'b1;
            if (i % (K4 + 2) == 0) push_exp(v);
            @(negedge clk);
        end
        bus4.valid_in = 1'b0;
        wait_done("b2b");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_outstanding: got %0d jobs pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send4({P3, P2, P1, M1});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_err_q.delete();
        acc_q.delete();
        @(negedge clk);
        checks++;
        if (bus4.busy !== 1'b0 || bus4.valid_out !== 1'b0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL abort: busy=%b valid_out=%b state=%0d required 0 0 0", bus4.busy, bus4.valid_out, st4);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        send4({PH, M1, P3, P1});
        wait_done("after_abort");
    endtask

    task automatic test_random();
        v4_t v;
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 4; j++) v[j] = rand_val();
            send4(v);
            wait_done("random");
        end
    endtask

    task automatic test_n2();
        int acc;
        int n;
        v2_t exp_v;
        exp_v = {P1, P2};
        bus2.unsorted = {P2, P1};
        bus2.valid_in = 1'b1;
        @(negedge clk);
        bus2.valid_in = 1'b0;
        acc = cyc;
        n = 0;
        while (bus2.valid_out !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus2.valid_out !== 1'b1 || cyc - acc !== K2) begin
            errors++;
            $display("FAIL n2_latency: got %0d valid_out=%b required %0d", cyc - acc, bus2.valid_out, K2);
        end
        checks++;
        if (bus2.sorted !== exp_v || bus2.err !== 1'b0) begin
            errors++;
            $display("FAIL n2_sorted: got %h err=%b required %h", bus2.sorted, bus2.err, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_n5();
        int acc;
        int n;
        v5_t exp_v;
        exp_v = {M1, PH, P1, P2, P3};
        bus5.unsorted = {PH, P3, M1, P2, P1};
        bus5.valid_in = 1'b1;
        @(negedge clk);
        bus5.valid_in = 1'b0;
        acc = cyc;
        n = 0;
        while (bus5.valid_out !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus5.valid_out !== 1'b1 || cyc - acc !== K5) begin
            errors++;
            $display("FAIL n5_latency: got %0d valid_out=%b required %0d", cyc - acc, bus5.valid_out, K5);
        end
        checks++;
        if (bus5.sorted !== exp_v || bus5.err !== 1'b0) begin
            errors++;
            $display("FAIL n5_sorted: got %h err=%b required %h", bus5.sorted, bus5.err, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus4.valid_in = 1'b0; bus4.unsorted = '0;
        bus2.valid_in = 1'b0; bus2.unsorted = '0;
        bus5.valid_in = 1'b0; bus5.unsorted = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_data_independent();
        test_nan();
        test_zeros();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_n2();
        test_n5();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
